// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single-outstanding imem port and a small FIFO feeding decode.
// Optional FETCH_PERF_EN adds perf_inst_cnt / perf_stall_cnt counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] fetched_inst,
    output logic [31:0] fetched_pc,
    output logic        inst_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_inst_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t      state, state_n;
    logic [31:0] next_pc, next_pc_n, addr_n;
    logic [31:0] mem_pc [FIFO_DEPTH];
    logic [31:0] mem_inst [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count, count_n;
    logic        ack, push, pop, credit, issue;

    // an ack with no request outstanding is never meaningful
    assign ack = imem_ack && imem_req;

    always_comb begin
        push = state == REQ && ack && !redirect_en;
        pop = !stall && !redirect_en && count != '0;
        count_n = redirect_en ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
        credit = count_n < DEPTH;
        state_n = state;
        issue = 1'b0;
        case (state)
            IDLE: if (credit && !redirect_en) begin
                issue = 1'b1;
                state_n = REQ;
            end
            REQ: if (ack) begin
                issue = push && credit;
                state_n = issue ? REQ : IDLE;
            end else if (redirect_en) begin
                state_n = DROP;
            end
            DROP: if (ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        addr_n = issue ? next_pc : imem_addr;
        next_pc_n = redirect_en ? redirect_pc & ~32'd3 : issue ? next_pc + 32'd4 : next_pc;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            imem_req <= 1'b0;
            imem_addr <= '0;
            next_pc <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            fetched_inst <= '0;
            fetched_pc <= '0;
            inst_valid <= 1'b0;
        end else begin
            state <= state_n;
            imem_req <= state_n != IDLE;
            imem_addr <= addr_n;
            next_pc <= next_pc_n;
            count <= count_n;
            rd_ptr <= redirect_en ? '0 : rd_ptr + AW'(pop);
            wr_ptr <= redirect_en ? '0 : wr_ptr + AW'(push);
            fetched_inst <= pop ? mem_inst[rd_ptr] : '0;
            fetched_pc <= pop ? mem_pc[rd_ptr] : '0;
            inst_valid <= pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr] <= imem_addr;
            mem_inst[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_inst_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_inst_cnt <= perf_inst_cnt + 32'(pop);
            perf_stall_cnt <= perf_stall_cnt + 32'(stall && count != '0);
        end
    end
`endif

    // credit accounting makes a push into a full buffer impossible
    assert property (@(posedge clk) disable iff (!reset_n) push |-> (count < DEPTH || pop));
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage, directly upstream of decode_unit. Fetches 32-bit words from instruction memory over a single-outstanding req/ack interface. Buffers them in a small FIFO and presents one instruction per cycle on fetched_inst, which is wired straight to decode_unit.fetched_inst. decode_unit has no valid or stall input, so empty cycles are presented as bubble word 32'h0000_0000 (opcode 0, which decodes to ALU_NONE).

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, instruction buffer entries; power of 2, at least 2.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
stall  in  1  downstream hold: no pop this cycle, bubble presented
redirect_en  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
imem_req  out  1  memory request, registered
imem_addr  out  32  request address, registered, stable while imem_req=1
imem_ack  in  1  request complete; imem_rdata valid this cycle
imem_rdata  in  32  returned instruction word
fetched_inst  out  32  instruction to decode_unit; 0 when not valid
fetched_pc  out  32  PC of fetched_inst; 0 when not valid
inst_valid  out  1  fetched_inst carries a real instruction

Behaviour:
- Reset (reset_n=0 at posedge), regardless of state or an in-flight request:
  - imem_req=0, imem_addr=0, fetched_inst=0, fetched_pc=0, inst_valid=0.
  - FIFO emptied, state IDLE, next_pc=RESET_PC.
  - A late imem_ack after reset is ignored.
- Memory protocol:
  - Only one request in flight.
  - imem_addr is held constant from the cycle imem_req rises until the ack cycle inclusive.
  - imem_ack seen while imem_req=0 is ignored.
- Credit: a new request may be issued only when count_next + inflight < FIFO_DEPTH.
  - count_next is FIFO occupancy after this cycle's push/pop.
  - inflight is 1 in REQ, 0 otherwise.
  - The stale request in DROP does not consume credit.
- State machine:
  - IDLE: if credit and no redirect, set imem_req<=1, imem_addr<=next_pc, next_pc<=next_pc+4, go to REQ.
  - REQ, ack without redirect: push {imem_addr, imem_rdata}. If credit remains, issue the next request in the same edge (back-to-back, stay REQ); otherwise imem_req<=0, go to IDLE.
  - REQ, redirect without ack: go to DROP, holding imem_req and imem_addr.
  - REQ, redirect with ack in the same cycle: discard the data, imem_req<=0, go to IDLE.
  - DROP: on ack, discard the data, imem_req<=0, go to IDLE. A redirect while in DROP updates next_pc only.
- Redirect: next_pc<=redirect_pc & ~3, FIFO flushed, outputs forced to a bubble on the next edge. Redirect has priority over stall and over a pop.
- Output register, updated every edge:
  - If !stall, no redirect and FIFO non-empty: pop head to fetched_inst/fetched_pc, inst_valid<=1.
  - Otherwise fetched_inst<=0, fetched_pc<=0, inst_valid<=0.
- Latency: ack at edge N pushes at N. Earliest visibility on fetched_inst is after edge N+1.
- Back-to-back with zero-wait memory (ack in the cycle after req) sustains 1 instruction per cycle once the pipeline fills.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC+4 = 0.
- FIFO full: no request issued. Push-on-full cannot occur because of credit; assert this in simulation.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds output perf_inst_cnt [31:0], incremented on each edge that sets inst_valid=1.
  - Adds output perf_stall_cnt [31:0], incremented on each edge where stall=1 and the FIFO is non-empty.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset then zero-wait memory returning word = addr ^ 32'h00000013 → first inst_valid with fetched_pc=0, fetched_inst=32'h13; then pc 4, 8, 12 on consecutive cycles.
2. Stall held for 3 cycles after pc 8 is presented → 3 bubble cycles (inst_valid=0, fetched_inst=0); next output is pc 12, nothing lost or duplicated; imem_req stays low while the FIFO is full.
3. redirect_en with redirect_pc=32'h0000_0102 while a request to 0x10 is unacked (ack delayed 3 cycles) → imem_addr stays 0x10 until its ack; that data is dropped; next request is at 0x100; first valid output has fetched_pc=0x100.
4. Redirect and ack in the same cycle in REQ → acked word never appears; next imem_addr = redirect target.
5. RESET_PC=32'hFFFF_FFF8 → requests to 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
6. reset_n low for one cycle mid-request, then a stale ack → outputs zero, stale ack ignored, refetch from RESET_PC; with FETCH_PERF_EN, both counters read 0 after reset.
